// File: rtl/mem_resp_if_if.sv
// Signal bundle for mem_resp_if: requester command/response channels and backend port.
// A transfer occurs on a rising edge where the valid (iREQ_REQ, oRESP_REQ, oBACK_REQ) is high and its stall (oREQ_LOCK, iRESP_LOCK, iBACK_BUSY) is low; iBACK_VALID cannot be stalled.
interface mem_resp_if_if;
    logic        iREQ_REQ;
    logic        oREQ_LOCK;
    logic [1:0]  iREQ_ORDER;
    logic        iREQ_RW;
    logic [31:0] iREQ_ADDR;
    logic [31:0] iREQ_DATA;
    logic        oRESP_REQ;
    logic        iRESP_LOCK;
    logic [63:0] oRESP_DATA;
    logic        oBACK_REQ;
    logic        oBACK_RW;
    logic        iBACK_BUSY;
    logic [31:0] oBACK_ADDR;
    logic [31:0] oBACK_DATA;
    logic [3:0]  oBACK_MASK;
    logic        iBACK_VALID;
    logic [63:0] iBACK_DATA;
    // Sequencer state: 0 IDLE, 1 ISSUE, 2 WAIT_RD, 3 RETURN.
    logic [1:0]  oDBG_STATE;

    modport slave (
        input  iREQ_REQ, iREQ_ORDER, iREQ_RW, iREQ_ADDR, iREQ_DATA,
        input  iRESP_LOCK, iBACK_BUSY, iBACK_VALID, iBACK_DATA,
        output oREQ_LOCK, oRESP_REQ, oRESP_DATA,
        output oBACK_REQ, oBACK_RW, oBACK_ADDR, oBACK_DATA, oBACK_MASK,
        output oDBG_STATE
    );

    modport master (
        output iREQ_REQ, iREQ_ORDER, iREQ_RW, iREQ_ADDR, iREQ_DATA,
        output iRESP_LOCK, iBACK_BUSY, iBACK_VALID, iBACK_DATA,
        input  oREQ_LOCK, oRESP_REQ, oRESP_DATA,
        input  oBACK_REQ, oBACK_RW, oBACK_ADDR, oBACK_DATA, oBACK_MASK,
        input  oDBG_STATE
    );
endinterface

// File: rtl/mem_resp_if.sv
// Queued memory request front-end: one backend access at a time, single outstanding read.
// Optional MEM_RESP_IF_BYTE_MASK_EN aligns the backend address to a word and derives byte enables.
module mem_resp_if #(
    parameter int P_QUEUE_DEPTH   = 4,
    parameter int P_QUEUE_DEPTH_N = 2
) (
    input  logic          iCLOCK,
    input  logic          inRESET,
    mem_resp_if_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]  order;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    localparam logic [P_QUEUE_DEPTH_N:0]   LP_FULL     = (P_QUEUE_DEPTH_N+1)'(P_QUEUE_DEPTH);
    localparam logic [P_QUEUE_DEPTH_N-1:0] LP_LAST_PTR = P_QUEUE_DEPTH_N'(P_QUEUE_DEPTH - 1);

    cmd_t                       queue_q [P_QUEUE_DEPTH];
    logic [P_QUEUE_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [P_QUEUE_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
    logic [P_QUEUE_DEPTH_N:0]   count_q, count_d;

    state_t      state_q;
    logic        back_req_q;
    logic        back_rw_q;
    logic [31:0] back_addr_q;
    logic [31:0] back_data_q;
    logic [3:0]  back_mask_q;
    logic        resp_req_q;
    logic [63:0] resp_data_q;

    logic        req_lock;
    logic        push;
    logic        pop;
    cmd_t        head;
    cmd_t        in_cmd;
    logic [31:0] head_addr;
    logic [3:0]  head_mask;

    assign req_lock = (count_q == LP_FULL);
    assign push     = bus.iREQ_REQ && !req_lock;
    // The head leaves the queue on the cycle the backend takes it.
    assign pop      = (state_q == ST_ISSUE) && !bus.iBACK_BUSY;
    assign head     = queue_q[rd_ptr_q];
    assign in_cmd   = '{order: bus.iREQ_ORDER, rw: bus.iREQ_RW,
                        addr: bus.iREQ_ADDR, data: bus.iREQ_DATA};

    always_comb begin
        head_addr = head.addr;
        head_mask = 4'b1111;
`ifdef MEM_RESP_IF_BYTE_MASK_EN
        head_addr = {head.addr[31:2], 2'b00};
        case (head.order)
            2'd0:    head_mask = 4'b0001 << head.addr[1:0];
            2'd1:    head_mask = head.addr[1] ? 4'b1100 : 4'b0011;
            default: head_mask = 4'b1111;
        endcase
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == LP_LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == LP_LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge iCLOCK) begin
        if (push) queue_q[wr_ptr_q] <= in_cmd;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q     <= ST_IDLE;
            back_req_q  <= 1'b0;
            back_rw_q   <= 1'b0;
            back_addr_q <= '0;
            back_data_q <= '0;
            back_mask_q <= '0;
            resp_req_q  <= 1'b0;
            resp_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Backend fields are captured once here so they stay frozen while busy.
                    if (count_q != '0) begin
                        state_q     <= ST_ISSUE;
                        back_req_q  <= 1'b1;
                        back_rw_q   <= head.rw;
                        back_addr_q <= head_addr;
                        back_data_q <= head.data;
                        back_mask_q <= head_mask;
                    end
                end
                ST_ISSUE: begin
                    if (!bus.iBACK_BUSY) begin
                        back_req_q <= 1'b0;
                        state_q    <= back_rw_q ? ST_IDLE : ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (bus.iBACK_VALID) begin
                        resp_data_q <= bus.iBACK_DATA;
                        resp_req_q  <= 1'b1;
                        state_q     <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    if (!bus.iRESP_LOCK) begin
                        resp_req_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.oREQ_LOCK  = req_lock;
    assign bus.oRESP_REQ  = resp_req_q;
    assign bus.oRESP_DATA = resp_data_q;
    assign bus.oBACK_REQ  = back_req_q;
    assign bus.oBACK_RW   = back_rw_q;
    assign bus.oBACK_ADDR = back_addr_q;
    assign bus.oBACK_DATA = back_data_q;
    assign bus.oBACK_MASK = back_mask_q;
    assign bus.oDBG_STATE = state_q;
endmodule

// File: tb/tb_mem_resp_if.sv
// Bench for mem_resp_if: directed scenarios plus a random phase, checked against a
// transaction-level model (command queue, one pending read, one pending response).
module tb_mem_resp_if;
    localparam int DEPTH = 4;

    logic iCLOCK  = 1'b0;
    logic inRESET = 1'b0;

    mem_resp_if_if bus ();

    mem_resp_if #(.P_QUEUE_DEPTH(DEPTH), .P_QUEUE_DEPTH_N(2)) dut (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .bus     (bus)
    );

    always #5 iCLOCK = ~iCLOCK;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: accepted-but-not-issued commands {order,rw,addr,data}.
    logic [66:0] exp_q[$];
    bit          rd_wait   = 1'b0;
    bit          resp_pend = 1'b0;
    logic [63:0] last_data = '0;
    int          cyc_no = 0, n_accept = 0, n_issue = 0, n_resp = 0, n_reads = 0;
    int          last_accept_cyc = 0, last_pop_cyc = 0;
    logic [31:0] last_back_addr = '0;
    logic [3:0]  last_back_mask = '0;

    task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected {backend address, byte mask}: a naturally aligned run of 1/2/4 byte lanes.
    function automatic logic [35:0] exp_addr_mask(input logic [1:0] order, input logic [31:0] addr);
`ifdef MEM_RESP_IF_BYTE_MASK_EN
        logic [3:0] m;
        int nbytes;
        int first;
        nbytes = (order == 2'd0) ? 1 : (order == 2'd1) ? 2 : 4;
        first  = (int'(addr[1:0]) / nbytes) * nbytes;
        m = '0;
        for (int i = 0; i < 4; i++) if (i >= first && i < first + nbytes) m[i] = 1'b1;
        return {addr[31:2], 2'b00, m};
`else
        return {addr, 4'b1111};
`endif
    endfunction

    task automatic set_cmd(input logic [1:0] o, input logic rw, input logic [31:0] a, input logic [31:0] d);
        bus.iREQ_REQ   = 1'b1;
        bus.iREQ_ORDER = o;
        bus.iREQ_RW    = rw;
        bus.iREQ_ADDR  = a;
        bus.iREQ_DATA  = d;
    endtask

    // One clock cycle: entered at posedge+1, checks at mid-cycle, returns at next posedge+1.
    task automatic cyc();
        logic [66:0] h;
        logic [35:0] am;
        bit          rd_n, rp_n;
        int          sz0;
        #4;
        rd_n = rd_wait;
        rp_n = resp_pend;
        sz0  = exp_q.size();
        ck("req_lock", 64'(bus.oREQ_LOCK), 64'(sz0 == DEPTH));
        ck("resp_req", 64'(bus.oRESP_REQ), 64'(resp_pend));
        ck("resp_data", bus.oRESP_DATA, last_data);
        if (rd_wait || resp_pend || sz0 == 0) begin
            ck("back_req_idle", 64'(bus.oBACK_REQ), 64'(0));
        end else if (bus.oBACK_REQ === 1'b1) begin
            h  = exp_q[0];
            am = exp_addr_mask(h[66:65], h[63:32]);
            ck("back_rw", 64'(bus.oBACK_RW), 64'(h[64]));
            ck("back_addr", 64'(bus.oBACK_ADDR), 64'(am[35:4]));
            ck("back_mask", 64'(bus.oBACK_MASK), 64'(am[3:0]));
            ck("back_data", 64'(bus.oBACK_DATA), 64'(h[31:0]));
            if (!bus.iBACK_BUSY) begin
                void'(exp_q.pop_front());
                n_issue++;
                last_pop_cyc   = cyc_no;
                last_back_addr = bus.oBACK_ADDR;
                last_back_mask = bus.oBACK_MASK;
                if (!h[64]) rd_n = 1'b1;
            end
        end
        if (bus.iBACK_VALID && rd_wait) begin
            last_data = bus.iBACK_DATA;
            rd_n = 1'b0;
            rp_n = 1'b1;
        end
        if (resp_pend && !bus.iRESP_LOCK) begin
            rp_n = 1'b0;
            n_resp++;
        end
        if (bus.iREQ_REQ && sz0 != DEPTH && inRESET) begin
            exp_q.push_back({bus.iREQ_ORDER, bus.iREQ_RW, bus.iREQ_ADDR, bus.iREQ_DATA});
            n_accept++;
            last_accept_cyc = cyc_no;
            if (!bus.iREQ_RW) n_reads++;
        end
        rd_wait   = rd_n;
        resp_pend = rp_n;
        @(posedge iCLOCK);
        #1;
        cyc_no++;
    endtask

    task automatic wait_issue(input int target);
        int k = 0;
        while (n_issue < target && k < 30) begin
            cyc();
            k++;
        end
        ck("issue_timeout", 64'(n_issue), 64'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int base_acc, base_iss;
        logic [63:0] rdata;

        bus.iREQ_REQ = 1'b0; bus.iREQ_ORDER = '0; bus.iREQ_RW = 1'b0;
        bus.iREQ_ADDR = '0; bus.iREQ_DATA = '0; bus.iRESP_LOCK = 1'b0;
        bus.iBACK_BUSY = 1'b0; bus.iBACK_VALID = 1'b0; bus.iBACK_DATA = '0;

        // Reset values
        repeat (2) @(posedge iCLOCK);
        #1;
        ck("rst_lock", 64'(bus.oREQ_LOCK), 64'(0));
        ck("rst_resp_req", 64'(bus.oRESP_REQ), 64'(0));
        ck("rst_resp_data", bus.oRESP_DATA, 64'(0));
        ck("rst_back_req", 64'(bus.oBACK_REQ), 64'(0));
        ck("rst_back_rw", 64'(bus.oBACK_RW), 64'(0));
        ck("rst_back_addr", 64'(bus.oBACK_ADDR), 64'(0));
        ck("rst_back_data", 64'(bus.oBACK_DATA), 64'(0));
        ck("rst_back_mask", 64'(bus.oBACK_MASK), 64'(0));
        ck("rst_state", 64'(bus.oDBG_STATE), 64'(0));
        inRESET = 1'b1;

        // Read at 0x1000: issue two cycles after accept, response one cycle after return
        set_cmd(2'd2, 1'b0, 32'h0000_1000, $urandom);
        cyc();
        bus.iREQ_REQ = 1'b0;
        ck("t1_accept", 64'(n_accept), 64'(1));
        wait_issue(1);
        ck("t1_issue_latency", 64'(last_pop_cyc - last_accept_cyc), 64'(2));
        cyc();
        cyc();
        bus.iBACK_VALID = 1'b1;
        bus.iBACK_DATA  = 64'h1122_3344_5566_7788;
        cyc();
        bus.iBACK_VALID = 1'b0;
        ck("t1_resp_req", 64'(bus.oRESP_REQ), 64'(1));
        ck("t1_resp_data", bus.oRESP_DATA, 64'h1122_3344_5566_7788);
        cyc();
        ck("t1_resp_count", 64'(n_resp), 64'(1));

        // Backend busy: four writes fill the queue, the fifth is held off
        bus.iBACK_BUSY = 1'b1;
        base_acc = n_accept;
        base_iss = n_issue;
        for (int i = 0; i < 5; i++) begin
            set_cmd(2'($urandom_range(0, 3)), 1'b1, 32'h100 + 32'(i * 4), $urandom);
            if (i < 4) cyc();
        end
        repeat (5) cyc();
        ck("t2_accepted", 64'(n_accept - base_acc), 64'(4));
        ck("t2_lock", 64'(bus.oREQ_LOCK), 64'(1));
        ck("t2_none_issued", 64'(n_issue - base_iss), 64'(0));
        bus.iBACK_BUSY = 1'b0;
        k = 0;
        while (n_accept - base_acc < 5 && k < 20) begin cyc(); k++; end
        bus.iREQ_REQ = 1'b0;
        k = 0;
        while (exp_q.size() > 0 && k < 40) begin cyc(); k++; end
        ck("t2_drained", 64'(exp_q.size()), 64'(0));
        ck("t2_issued", 64'(n_issue - base_iss), 64'(5));
        ck("t2_lock_drop", 64'(bus.oREQ_LOCK), 64'(0));

        // Response stalled for 10 cycles; the queued write must wait for the transfer
        bus.iRESP_LOCK = 1'b1;
        set_cmd(2'd2, 1'b0, 32'h40, $urandom);
        cyc();
        set_cmd(2'd2, 1'b1, 32'h44, $urandom);
        cyc();
        bus.iREQ_REQ = 1'b0;
        k = 0;
        while (!rd_wait && k < 20) begin cyc(); k++; end
        rdata = {$urandom, $urandom};
        bus.iBACK_VALID = 1'b1;
        bus.iBACK_DATA  = rdata;
        cyc();
        bus.iBACK_VALID = 1'b0;
        base_iss = n_issue;
        repeat (10) cyc();
        ck("t3_write_held", 64'(n_issue - base_iss), 64'(0));
        ck("t3_resp_held", 64'(bus.oRESP_REQ), 64'(1));
        ck("t3_data_held", bus.oRESP_DATA, rdata);
        bus.iRESP_LOCK = 1'b0;
        cyc();
        wait_issue(base_iss + 1);
        ck("t3_data_retained", bus.oRESP_DATA, rdata);

        // Byte and half writes: address alignment and byte enables
        set_cmd(2'd0, 1'b1, 32'h0000_0003, $urandom);
        cyc();
        bus.iREQ_REQ = 1'b0;
        wait_issue(n_issue + 1);
`ifdef MEM_RESP_IF_BYTE_MASK_EN
        ck("t4_byte_addr", 64'(last_back_addr), 64'(32'h0));
        ck("t4_byte_mask", 64'(last_back_mask), 64'(4'b1000));
`else
        ck("t4_byte_addr", 64'(last_back_addr), 64'(32'h3));
        ck("t4_byte_mask", 64'(last_back_mask), 64'(4'b1111));
`endif
        set_cmd(2'd1, 1'b1, 32'h0000_0002, $urandom);
        cyc();
        bus.iREQ_REQ = 1'b0;
        wait_issue(n_issue + 1);
`ifdef MEM_RESP_IF_BYTE_MASK_EN
        ck("t4_half_addr", 64'(last_back_addr), 64'(32'h0));
        ck("t4_half_mask", 64'(last_back_mask), 64'(4'b1100));
`else
        ck("t4_half_addr", 64'(last_back_addr), 64'(32'h2));
        ck("t4_half_mask", 64'(last_back_mask), 64'(4'b1111));
`endif

        // Random traffic with random stalls and stray backend returns
        for (int i = 0; i < 600; i++) begin
            bus.iREQ_REQ    = 1'($urandom_range(0, 1));
            bus.iREQ_ORDER  = 2'($urandom_range(0, 3));
            bus.iREQ_RW     = 1'($urandom_range(0, 1));
            bus.iREQ_ADDR   = $urandom;
            bus.iREQ_DATA   = $urandom;
            bus.iBACK_BUSY  = ($urandom_range(0, 2) == 0);
            bus.iRESP_LOCK  = ($urandom_range(0, 2) == 0);
            bus.iBACK_VALID = ($urandom_range(0, 3) == 0);
            bus.iBACK_DATA  = {$urandom, $urandom};
            cyc();
        end
        bus.iREQ_REQ = 1'b0; bus.iBACK_BUSY = 1'b0; bus.iRESP_LOCK = 1'b0;
        k = 0;
        while ((exp_q.size() > 0 || rd_wait || resp_pend) && k < 300) begin
            bus.iBACK_VALID = 1'($urandom_range(0, 1));
            bus.iBACK_DATA  = {$urandom, $urandom};
            cyc();
            k++;
        end
        bus.iBACK_VALID = 1'b0;
        ck("t5_drained", 64'(exp_q.size()), 64'(0));
        ck("t5_reads_answered", 64'(n_resp), 64'(n_reads));

        // Reset while waiting on a read with two commands queued
        set_cmd(2'd2, 1'b0, 32'h200, $urandom);
        cyc();
        set_cmd(2'd2, 1'b1, 32'h204, $urandom);
        cyc();
        set_cmd(2'd2, 1'b1, 32'h208, $urandom);
        cyc();
        bus.iREQ_REQ = 1'b0;
        k = 0;
        while (!(rd_wait && exp_q.size() == 2) && k < 20) begin cyc(); k++; end
        ck("t6_wait_rd_state", 64'(bus.oDBG_STATE), 64'(2));
        #2;
        inRESET = 1'b0;
        #1;
        ck("t6_lock", 64'(bus.oREQ_LOCK), 64'(0));
        ck("t6_resp_req", 64'(bus.oRESP_REQ), 64'(0));
        ck("t6_resp_data", bus.oRESP_DATA, 64'(0));
        ck("t6_back_req", 64'(bus.oBACK_REQ), 64'(0));
        ck("t6_back_rw", 64'(bus.oBACK_RW), 64'(0));
        ck("t6_back_addr", 64'(bus.oBACK_ADDR), 64'(0));
        ck("t6_back_data", 64'(bus.oBACK_DATA), 64'(0));
        ck("t6_back_mask", 64'(bus.oBACK_MASK), 64'(0));
        ck("t6_state", 64'(bus.oDBG_STATE), 64'(0));
        exp_q.delete();
        rd_wait   = 1'b0;
        resp_pend = 1'b0;
        last_data = '0;
        @(posedge iCLOCK);
        #1;
        cyc();
        inRESET = 1'b1;
        bus.iBACK_VALID = 1'b1;
        bus.iBACK_DATA  = {$urandom, $urandom};
        cyc();
        bus.iBACK_VALID = 1'b0;
        repeat (5) cyc();
        ck("t6_no_resp", 64'(bus.oRESP_REQ), 64'(0));
        ck("t6_idle_after", 64'(bus.oDBG_STATE), 64'(0));
        ck("t6_no_issue", 64'(bus.oBACK_REQ), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
